// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
//   Instruction-memory read channel between the fetch unit and instruction
//   memory. One read per request, completed by a single-cycle ack.
//
//   Signals:
//     imem_req    fetch unit -> memory   read request (level)
//     imem_addr   fetch unit -> memory   read address, stable while req=1
//     imem_ack    memory -> fetch unit   read complete, rdata valid this cycle
//     imem_rdata  memory -> fetch unit   instruction word
//
//   Modports: master = fetch unit side, slave = memory side.
// ---------------------------------------------------------------------------
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch front end, producer side of the IF/ID register.
//   Holds the PC, issues one read per instruction over the imem channel,
//   packs {pc, instr} into if_packet and raises if_valid (IF/ID EN) while
//   the packet is presented. Lends the instruction bus to DMA between
//   fetches and handles stall and branch redirect.
//
//   Ports:
//     clk            clock, rising edge
//     rst            asynchronous active-high reset
//     stall          hold the presented packet (IF/ID must not advance)
//     branch_taken   single-cycle redirect pulse
//     branch_target  redirect PC, sampled with branch_taken
//     imem           instruction read channel (master side)
//     dma_busreq     DMA asks for the instruction bus
//     dma_busgrant   instruction bus lent to DMA
//     if_packet      {pc, instr} to IF/ID
//     if_valid       packet valid, IF/ID EN (0 = bubble)
//     fetch_err      sticky ack-timeout flag, cleared only by rst
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter int          N        = 63,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [31:0]           branch_target,
    if_fetch_unit_if.master       imem,
    input  logic                  dma_busreq,
    output logic                  dma_busgrant,
    output logic [N:0]            if_packet,
    output logic                  if_valid,
    output logic                  fetch_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DMA   = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic        squash;
    logic [7:0]  wait_cnt;

    // A fetch completes (packet captured) only for an ack that is neither
    // carrying a stale squashed request nor racing a fresh redirect.
    logic fetch_done;
    assign fetch_done = imem.imem_ack && !squash && !branch_taken;

    // Where to go once the current packet has left HOLD.
    state_t after_hold;
    assign after_hold = dma_busreq ? DMA : FETCH;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and Moore outputs
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next     = state;
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc;
        dma_busgrant   = 1'b0;
        if_valid       = 1'b0;

        case (state)
            IDLE: begin
                state_next = dma_busreq ? DMA : FETCH;
            end
            FETCH: begin
                imem.imem_req = 1'b1;
                if (fetch_done) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if_valid = 1'b1;
                // Redirect wins over stall: the held packet is on the wrong path.
                if (branch_taken || !stall) begin
                    state_next = after_hold;
                end
            end
            DMA: begin
                dma_busgrant = 1'b1;
                if (!dma_busreq) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // PC, packet, squash bookkeeping and ack-timeout watchdog
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            if_packet <= '0;
            squash    <= 1'b0;
            pend_pc   <= '0;
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem.imem_ack) begin
                        wait_cnt <= '0;
                        if (squash || branch_taken) begin
                            // Read was for the old path: drop the data and
                            // re-request at the redirect address.
                            pc     <= branch_taken ? branch_target : pend_pc;
                            squash <= 1'b0;
                        end else begin
                            if_packet <= {pc, imem.imem_rdata};
                            pc        <= pc + 32'd4;
                        end
                    end else begin
                        // Saturate so a long-dead memory cannot wrap the count.
                        if (wait_cnt != TIMEOUT_CNT) begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end else begin
                            fetch_err <= 1'b1;
                        end
                        // The address must stay stable while req is high, so
                        // a redirect is parked until the outstanding ack.
                        if (branch_taken) begin
                            squash  <= 1'b1;
                            pend_pc <= branch_target;
                        end
                    end
                end
                HOLD, DMA: begin
                    if (branch_taken) begin
                        pc <= branch_target;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//   Directed bench for if_fetch_unit. The bench plays instruction memory,
//   pushes the expected {addr, data} packet when it returns an ack and pops
//   it when if_valid shows up. Inputs change and outputs are sampled on the
//   falling clock edge.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        dma_busreq;
    logic        dma_busgrant;
    logic [63:0] if_packet;
    logic        if_valid;
    logic        fetch_err;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .N        (63),
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (255)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (bus),
        .dma_busreq    (dma_busreq),
        .dma_busgrant  (dma_busgrant),
        .if_packet     (if_packet),
        .if_valid      (if_valid),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] sb[$];
    logic [63:0] last_pkt;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bounded wait for imem_req; an expired bound shows up as a failed check.
    task automatic wait_req();
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        chk("imem_req_seen", 64'(bus.imem_req), 64'd1);
    endtask

    // Serve one read at the expected address and check the presented packet.
    // Returns at the falling edge of the first HOLD cycle.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data);
        wait_req();
        chk("imem_addr", 64'(bus.imem_addr), 64'(addr));
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        sb.push_back({addr, data});
        step();
        bus.imem_ack = 1'b0;
        chk("if_valid_hold", 64'(if_valid), 64'd1);
        last_pkt = sb.pop_front();
        chk("if_packet", if_packet, last_pkt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        stall          = 1'b0;
        branch_taken   = 1'b0;
        branch_target  = 32'h0;
        dma_busreq     = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        repeat (2) step();

        // Reset state
        chk("rst_req",   64'(bus.imem_req),  64'd0);
        chk("rst_grant", 64'(dma_busgrant),  64'd0);
        chk("rst_valid", 64'(if_valid),      64'd0);
        chk("rst_err",   64'(fetch_err),     64'd0);
        chk("rst_addr",  64'(bus.imem_addr), 64'd0);
        chk("rst_pkt",   if_packet,          64'd0);
        rst = 1'b0;

        // Back-to-back fetches 0,4,8; if_valid is a one-cycle pulse each time
        for (int a = 0; a < 12; a += 4) begin
            do_fetch(32'(a), 32'hA000_0000 + 32'(a));
            step();
            chk("valid_one_cycle", 64'(if_valid), 64'd0);
        end

        // Stall in HOLD with packet {0x10, DEADBEEF}
        do_fetch(32'h0C, 32'hA000_000C);
        step();
        do_fetch(32'h10, 32'hDEAD_BEEF);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", 64'(if_valid), 64'd1);
            chk("stall_pkt",   if_packet,     last_pkt);
        end
        stall = 1'b0;
        step();
        chk("post_stall_valid", 64'(if_valid),      64'd0);
        chk("post_stall_addr",  64'(bus.imem_addr), 64'h14);

        for (int a = 32'h14; a < 32'h40; a += 4) begin
            do_fetch(32'(a), 32'hA000_0000 + 32'(a));
            step();
        end

        // Branch two cycles before the ack at 0x40: data discarded
        chk("br_addr0", 64'(bus.imem_addr), 64'h40);
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        step();
        branch_taken  = 1'b0;
        branch_target = 32'hDEAD_0000;
        step();
        chk("br_addr_stable", 64'(bus.imem_addr), 64'h40);
        chk("br_req_stable",  64'(bus.imem_req),  64'd1);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hA000_0040;
        step();
        bus.imem_ack = 1'b0;
        chk("br_no_valid", 64'(if_valid),      64'd0);
        chk("br_new_addr", 64'(bus.imem_addr), 64'h200);
        do_fetch(32'h200, 32'hA000_0200);

        // Branch in HOLD beats stall
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h300;
        step();
        stall        = 1'b0;
        branch_taken = 1'b0;
        chk("hold_br_valid", 64'(if_valid),      64'd0);
        chk("hold_br_req",   64'(bus.imem_req),  64'd1);
        chk("hold_br_addr",  64'(bus.imem_addr), 64'h300);

        // Asynchronous reset mid-FETCH
        #2 rst = 1'b1;
        #1;
        chk("arst_f_req",   64'(bus.imem_req),  64'd0);
        chk("arst_f_valid", 64'(if_valid),      64'd0);
        chk("arst_f_addr",  64'(bus.imem_addr), 64'd0);
        step();
        rst = 1'b0;

        // DMA request during FETCH at 0x8: grant only after the packet leaves
        do_fetch(32'h0, 32'hA000_0000);
        step();
        do_fetch(32'h4, 32'hA000_0004);
        step();
        dma_busreq = 1'b1;
        step();
        chk("dma_req_held", 64'(bus.imem_req), 64'd1);
        chk("dma_no_grant", 64'(dma_busgrant), 64'd0);
        do_fetch(32'h8, 32'hA000_0008);
        step();
        chk("dma_grant",    64'(dma_busgrant), 64'd1);
        chk("dma_req_low",  64'(bus.imem_req), 64'd0);
        chk("dma_valid",    64'(if_valid),     64'd0);
        step();
        chk("dma_grant_stay", 64'(dma_busgrant), 64'd1);
        dma_busreq = 1'b0;
        step();
        chk("dma_release", 64'(dma_busgrant),  64'd0);
        chk("dma_refetch", 64'(bus.imem_req),  64'd1);
        chk("dma_addr",    64'(bus.imem_addr), 64'hC);

        // Asynchronous reset mid-DMA
        do_fetch(32'hC, 32'hA000_000C);
        dma_busreq = 1'b1;
        step();
        chk("dma2_grant", 64'(dma_busgrant), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_d_grant", 64'(dma_busgrant),  64'd0);
        chk("arst_d_req",   64'(bus.imem_req),  64'd0);
        chk("arst_d_addr",  64'(bus.imem_addr), 64'd0);
        dma_busreq = 1'b0;
        step();
        rst = 1'b0;

        // Ack withheld for 300 cycles: fetch_err sets and stays set
        repeat (250) step();
        chk("to_err_early", 64'(fetch_err),    64'd0);
        chk("to_req_held",  64'(bus.imem_req), 64'd1);
        repeat (50) step();
        chk("to_err_set",   64'(fetch_err),    64'd1);
        do_fetch(32'h0, 32'hA000_0000);
        step();
        chk("to_err_sticky", 64'(fetch_err),      64'd1);
        chk("to_next_addr",  64'(bus.imem_addr),  64'h4);
        #2 rst = 1'b1;
        #1;
        chk("to_err_clear", 64'(fetch_err), 64'd0);
        step();
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
